// File: rtl/select_result_accum_if.sv
// Sample/result bus for select_result_accum.
// master: the producer/consumer side; slave: the accumulator block.
interface select_result_accum_if #(
  parameter int unsigned IN_W    = 9,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned WIN_LEN = 8
);
  localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_ready;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic signed [IN_W-1:0]  out_min;
  logic signed [IN_W-1:0]  out_max;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_min, out_max, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_min, out_max, out_count, out_ovf
  );
endinterface

// File: rtl/select_result_accum.sv
// Windowed accumulator for the signed operand-select result stream.
// Collects WIN_LEN samples (or fewer on flush) and presents sum/min/max/count/ovf
// through a one-entry result register that holds under backpressure.
// Optional macro ACCUM_SAT_EN: saturate each addition instead of wrapping.
module select_result_accum #(
  parameter int unsigned IN_W    = 9,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned WIN_LEN = 8
) (
  input logic                  clk,
  input logic                  rst,
  select_result_accum_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] WinLenC = CNT_W'(WIN_LEN);
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e state_q, state_d;

  // Running window state
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [IN_W-1:0]  min_q, max_q;
  logic                    ovf_q;

  // Result holding register
  logic signed [ACC_W-1:0] res_sum_q;
  logic signed [IN_W-1:0]  res_min_q, res_max_q;
  logic [CNT_W-1:0]        res_cnt_q;
  logic                    res_ovf_q;

  logic                    in_rdy, out_vld;
  logic                    accept, handshake, flush_hit, close;
  logic signed [ACC_W-1:0] sample_ext, sum_next;
  logic [ACC_W:0]          sum_wide;
  logic                    add_ovf, ovf_next, first;
  logic [CNT_W-1:0]        cnt_inc;
  logic signed [IN_W-1:0]  min_next, max_next;

  // Next window values assuming the current sample is accepted
  always_comb begin
    sample_ext = ACC_W'(bus.in_data);
    // One guard bit: overflow iff the two top bits disagree
    sum_wide   = {acc_q[ACC_W-1], acc_q} + {sample_ext[ACC_W-1], sample_ext};
    add_ovf    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
`ifdef ACCUM_SAT_EN
    if (add_ovf) begin
      sum_next = sum_wide[ACC_W] ? AccMin : AccMax;
    end else begin
      sum_next = sum_wide[ACC_W-1:0];
    end
`else
    sum_next   = sum_wide[ACC_W-1:0];
`endif
    ovf_next   = ovf_q | add_ovf;
    first      = (cnt_q == '0);
    cnt_inc    = cnt_q + CNT_W'(1);
    min_next   = (first || (bus.in_data < min_q)) ? bus.in_data : min_q;
    max_next   = (first || (bus.in_data > max_q)) ? bus.in_data : max_q;
  end

  // Handshake and window-close decode
  always_comb begin
    accept    = bus.in_valid & in_rdy;
    handshake = out_vld & bus.out_ready;
    // Flush only closes a non-empty window, and is ignored while a result is held
    flush_hit = bus.flush & (state_q == StAccum) & ((cnt_q != '0) | accept);
    close     = (accept & (cnt_inc == WinLenC)) | flush_hit;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (close) state_d = StHold;
      // A handshake-cycle sample may itself close a new window (WIN_LEN=1)
      StHold:  if (handshake) state_d = close ? StHold : StAccum;
    endcase
  end

  // Output decode; in_ready in HOLD follows out_ready combinationally
  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StAccum: in_rdy = 1'b1;
        StHold: begin
          in_rdy  = bus.out_ready;
          out_vld = 1'b1;
        end
      endcase
    end
  end

  // Window accumulation and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else if (close) begin
      res_sum_q <= accept ? sum_next : acc_q;
      res_min_q <= accept ? min_next : min_q;
      res_max_q <= accept ? max_next : max_q;
      res_cnt_q <= accept ? cnt_inc  : cnt_q;
      res_ovf_q <= accept ? ovf_next : ovf_q;
      acc_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      acc_q <= sum_next;
      cnt_q <= cnt_inc;
      min_q <= min_next;
      max_q <= max_next;
      ovf_q <= ovf_next;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_sum   = res_sum_q;
  assign bus.out_min   = res_min_q;
  assign bus.out_max   = res_max_q;
  assign bus.out_count = res_cnt_q;
  assign bus.out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_select_result_accum.sv
// Bench for select_result_accum: directed window table, hand-written corner
// sequences, a WIN_LEN=1 instance, and a randomized run against a queue model.
module tb_select_result_accum;

  localparam int AccW  = 10;
  localparam int AMax  = 511;
  localparam int AMin  = -512;
  localparam int AMod  = 1024;
  localparam int WinA  = 4;

`ifdef ACCUM_SAT_EN
  localparam int SumPos4 = 511;
  localparam int SumNeg4 = -512;
`else
  localparam int SumPos4 = -4;
  localparam int SumNeg4 = 0;
`endif

  logic clk;
  logic rst;

  select_result_accum_if #(.IN_W(9), .ACC_W(AccW), .WIN_LEN(WinA)) bus_a ();
  select_result_accum_if #(.IN_W(9), .ACC_W(16), .WIN_LEN(1)) bus_b ();

  select_result_accum #(.IN_W(9), .ACC_W(AccW), .WIN_LEN(WinA)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  select_result_accum #(.IN_W(9), .ACC_W(16), .WIN_LEN(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int n;
    int s0, s1, s2, s3;
    int mode;  // 0: no flush, 1: flush in a later cycle, 2: flush with last sample
    int sum, mn, mx, cnt, ovf;
  } vec_t;

  vec_t vecs[6];

  // Reference model state
  int  win_q[$];
  bit  m_hold;
  int  e_sum, e_min, e_max, e_cnt, e_ovf;

  function automatic vec_t mk(int n, int a, int b, int c, int d, int mode,
                              int sum, int mn, int mx, int cnt, int ovf);
    vec_t v;
    v.n = n; v.s0 = a; v.s1 = b; v.s2 = c; v.s3 = d; v.mode = mode;
    v.sum = sum; v.mn = mn; v.mx = mx; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  function automatic int sample_of(vec_t v, int k);
    case (k)
      0: return v.s0;
      1: return v.s1;
      2: return v.s2;
      default: return v.s3;
    endcase
  endfunction

  // Window result from the list of accepted samples, adding one at a time
  function automatic void model_close();
    int acc = 0;
    int ovf = 0;
    int t;
    e_min = win_q[0];
    e_max = win_q[0];
    foreach (win_q[i]) begin
      t = acc + win_q[i];
      if (t > AMax || t < AMin) begin
        ovf = 1;
`ifdef ACCUM_SAT_EN
        t = (t > AMax) ? AMax : AMin;
`else
        t = (t > AMax) ? t - AMod : t + AMod;
`endif
      end
      acc = t;
      if (win_q[i] < e_min) e_min = win_q[i];
      if (win_q[i] > e_max) e_max = win_q[i];
    end
    e_sum = acc;
    e_cnt = win_q.size();
    e_ovf = ovf;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit fl);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 9'(d);
    bus_a.flush    = fl;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.flush    = 1'b0;
  endtask

  task automatic check_res(input string tag, input int s, input int mn, input int mx,
                           input int c, input int o);
    check({tag, "_valid"}, int'(bus_a.out_valid), 1);
    check({tag, "_sum"},   int'(bus_a.out_sum), s);
    check({tag, "_min"},   int'(bus_a.out_min), mn);
    check({tag, "_max"},   int'(bus_a.out_max), mx);
    check({tag, "_count"}, int'(bus_a.out_count), c);
    check({tag, "_ovf"},   int'(bus_a.out_ovf), o);
  endtask

  initial begin
    bit iv, fl, ordy, exp_rdy, was_hold, acc;
    int d;

    vecs[0] = mk(4, 10, -3, 100, -256, 0, -149, -256, 100, 4, 0);
    vecs[1] = mk(2, 5, -5, 0, 0, 1, 0, -5, 5, 2, 0);
    vecs[2] = mk(3, 1, 2, 3, 0, 2, 6, 1, 3, 3, 0);
    vecs[3] = mk(4, 255, 255, 255, 255, 0, SumPos4, 255, 255, 4, 1);
    vecs[4] = mk(4, -256, -256, -256, -256, 0, SumNeg4, -256, -256, 4, 1);
    vecs[5] = mk(4, 7, 0, -1, 3, 0, 9, -1, 7, 4, 0);

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", int'(bus_a.in_ready), 0);
    check("rst_out_valid", int'(bus_a.out_valid), 0);
    check("rst_sum", int'(bus_a.out_sum), 0);
    check("rst_min", int'(bus_a.out_min), 0);
    check("rst_max", int'(bus_a.out_max), 0);
    check("rst_count", int'(bus_a.out_count), 0);
    check("rst_ovf", int'(bus_a.out_ovf), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(bus_a.in_ready), 1);

    // Directed windows
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        send(sample_of(vecs[i], k), (vecs[i].mode == 2) && (k == vecs[i].n - 1));
      end
      if (vecs[i].mode == 1) begin
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
      end
      check_res($sformatf("vec%0d", i), vecs[i].sum, vecs[i].mn, vecs[i].mx,
                vecs[i].cnt, vecs[i].ovf);
      tick();
      check($sformatf("vec%0d_release", i), int'(bus_a.out_valid), 0);
    end

    // Backpressure: result must hold while out_ready is low
    bus_a.out_ready = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    for (int c = 0; c < 5; c++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 9'sd99;
      #1;
      check("bp_in_ready", int'(bus_a.in_ready), 0);
      check("bp_out_valid", int'(bus_a.out_valid), 1);
      check("bp_sum", int'(bus_a.out_sum), 10);
      check("bp_count", int'(bus_a.out_count), 4);
      tick();
    end
    bus_a.out_ready = 1'b1;
    bus_a.in_data   = 9'sd7;
    #1;
    check("bp_handshake_in_ready", int'(bus_a.in_ready), 1);
    tick();
    bus_a.in_valid = 1'b0;
    check("bp_release", int'(bus_a.out_valid), 0);
    bus_a.flush = 1'b1;
    tick();
    bus_a.flush = 1'b0;
    check_res("bp_next", 7, 7, 7, 1, 0);
    tick();

    // Flush on an empty window does nothing
    bus_a.flush = 1'b1;
    tick();
    bus_a.flush = 1'b0;
    check("flush_empty_0", int'(bus_a.out_valid), 0);
    tick();
    check("flush_empty_1", int'(bus_a.out_valid), 0);

    // Reset mid-window discards the partial window
    send(50, 0);
    send(50, 0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus_a.in_ready), 0);
    tick();
    rst = 1'b0;
    check("midrst_out_valid", int'(bus_a.out_valid), 0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    check_res("midrst", 10, 1, 4, 4, 0);
    tick();

    // WIN_LEN=1: back-to-back samples each close a window
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 9'sd8;
    tick();
    check("w1_valid0", int'(bus_b.out_valid), 1);
    check("w1_sum0", int'(bus_b.out_sum), 8);
    check("w1_count0", int'(bus_b.out_count), 1);
    bus_b.in_data = -9'sd8;
    tick();
    check("w1_valid1", int'(bus_b.out_valid), 1);
    check("w1_sum1", int'(bus_b.out_sum), -8);
    check("w1_min1", int'(bus_b.out_min), -8);
    bus_b.in_data = 9'sd0;
    tick();
    check("w1_valid2", int'(bus_b.out_valid), 1);
    check("w1_sum2", int'(bus_b.out_sum), 0);
    bus_b.in_valid = 1'b0;
    tick();
    check("w1_release", int'(bus_b.out_valid), 0);

    // Randomized run against the queue model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    win_q.delete();
    m_hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      iv   = ($urandom_range(0, 9) < 7);
      d    = int'($urandom_range(0, 511)) - 256;
      fl   = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      bus_a.in_valid  = iv;
      bus_a.in_data   = 9'(d);
      bus_a.flush     = fl;
      bus_a.out_ready = ordy;
      #1;
      exp_rdy = !m_hold || ordy;
      check("rnd_in_ready", int'(bus_a.in_ready), int'(exp_rdy));
      check("rnd_out_valid", int'(bus_a.out_valid), int'(m_hold));
      if (m_hold) begin
        check("rnd_sum", int'(bus_a.out_sum), e_sum);
        check("rnd_min", int'(bus_a.out_min), e_min);
        check("rnd_max", int'(bus_a.out_max), e_max);
        check("rnd_count", int'(bus_a.out_count), e_cnt);
        check("rnd_ovf", int'(bus_a.out_ovf), e_ovf);
      end
      was_hold = m_hold;
      acc      = iv && exp_rdy;
      if (m_hold && ordy) m_hold = 1'b0;
      if (acc) win_q.push_back(d);
      if ((acc && win_q.size() == WinA) || (fl && !was_hold && win_q.size() > 0)) begin
        model_close();
        win_q.delete();
        m_hold = 1'b1;
      end
      tick();
    end
    bus_a.in_valid = 1'b0;
    bus_a.flush    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
